// File: rtl/axi_lite_cfg_regs.sv
// AXI4-Lite configuration register file: NumRegs words with reset values, a
// read-only mask, a hardware load path and registered B/R responses.

package axi_lite_cfg_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } resp_t;
endpackage

module axi_lite_cfg_regs #(
    parameter int unsigned                       NumRegs      = 32'd4,
    parameter int unsigned                       AxiAddrWidth = 32'd32,
    parameter int unsigned                       AxiDataWidth = 32'd32,
    parameter logic [NumRegs*AxiDataWidth-1:0]   RegRstVal    = '0,
    parameter logic [NumRegs-1:0]                ReadOnly     = '0,
    parameter type                               req_t        = axi_lite_cfg_pkg::req_t,
    parameter type                               resp_t       = axi_lite_cfg_pkg::resp_t
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  req_t                              slv_req_i,
    output resp_t                             slv_resp_o,
    input  logic [NumRegs-1:0]                reg_load_i,
    input  logic [NumRegs*AxiDataWidth-1:0]   reg_d_i,
    output logic [NumRegs*AxiDataWidth-1:0]   reg_q_o,
    output logic [NumRegs-1:0]                wr_pulse_o
);

    localparam int unsigned RegIdxWidth = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam int unsigned WordOffset  = $clog2(AxiDataWidth / 8);
    localparam int unsigned StrbWidth   = AxiDataWidth / 8;
    localparam logic [1:0]  RespOkay    = 2'b00;
    localparam logic [1:0]  RespSlvErr  = 2'b10;

    typedef logic [AxiDataWidth-1:0] word_t;

    word_t                  regs_q [NumRegs];
    word_t                  regs_d [NumRegs];
    logic                   b_valid_q, b_valid_d;
    logic [1:0]             b_resp_q, b_resp_d;
    logic                   r_valid_q, r_valid_d;
    logic [1:0]             r_resp_q, r_resp_d;
    word_t                  r_data_q, r_data_d;
    logic [NumRegs-1:0]     wr_pulse_q, wr_pulse_d;

    logic [RegIdxWidth-1:0] wr_idx, rd_idx;
    logic                   wr_in_range, wr_ro, wr_ok, wr_acc;
    logic                   rd_in_range, ar_ready, rd_acc;
    word_t                  rd_data;

    // The whole word address must be below NumRegs; this also rejects any
    // set bit above the index field.
    function automatic logic in_range(input logic [AxiAddrWidth-1:0] addr);
        return (addr >> WordOffset) < AxiAddrWidth'(NumRegs);
    endfunction

    always_comb begin
        wr_idx      = slv_req_i.aw.addr[WordOffset +: RegIdxWidth];
        wr_in_range = in_range(slv_req_i.aw.addr);
        wr_ro       = 1'b0;
        for (int k = 0; k < NumRegs; k++) begin
            if (wr_idx == RegIdxWidth'(k)) wr_ro = ReadOnly[k];
        end
        wr_ok  = wr_in_range && !wr_ro;
        wr_acc = rst_ni && slv_req_i.aw_valid && slv_req_i.w_valid
                 && (!b_valid_q || slv_req_i.b_ready);

        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        wr_pulse_d = '0;
        if (wr_acc) begin
            b_valid_d = 1'b1;
            b_resp_d  = wr_ok ? RespOkay : RespSlvErr;
        end else if (slv_req_i.b_ready) begin
            b_valid_d = 1'b0;
        end

        // Load first, then strobed AXI bytes override it.
        for (int k = 0; k < NumRegs; k++) begin
            regs_d[k] = regs_q[k];
            if (reg_load_i[k]) regs_d[k] = reg_d_i[k*AxiDataWidth +: AxiDataWidth];
            if (wr_acc && wr_ok && (wr_idx == RegIdxWidth'(k))) begin
                wr_pulse_d[k] = 1'b1;
                for (int b = 0; b < StrbWidth; b++) begin
                    if (slv_req_i.w.strb[b]) regs_d[k][8*b +: 8] = slv_req_i.w.data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_idx      = slv_req_i.ar.addr[WordOffset +: RegIdxWidth];
        rd_in_range = in_range(slv_req_i.ar.addr);
        ar_ready    = rst_ni && (!r_valid_q || slv_req_i.r_ready);
        rd_acc      = slv_req_i.ar_valid && ar_ready;

        rd_data = '0;
        for (int k = 0; k < NumRegs; k++) begin
            if (rd_in_range && (rd_idx == RegIdxWidth'(k))) rd_data = regs_q[k];
        end

        r_valid_d = r_valid_q;
        r_resp_d  = r_resp_q;
        r_data_d  = r_data_q;
        if (rd_acc) begin
            r_valid_d = 1'b1;
            r_resp_d  = rd_in_range ? RespOkay : RespSlvErr;
            r_data_d  = rd_data;
        end else if (slv_req_i.r_ready) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumRegs; k++) begin
                regs_q[k] <= RegRstVal[k*AxiDataWidth +: AxiDataWidth];
            end
            b_valid_q  <= 1'b0;
            b_resp_q   <= '0;
            r_valid_q  <= 1'b0;
            r_resp_q   <= '0;
            r_data_q   <= '0;
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            r_valid_q  <= r_valid_d;
            r_resp_q   <= r_resp_d;
            r_data_q   <= r_data_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = wr_acc;
        slv_resp_o.w_ready  = wr_acc;
        slv_resp_o.b_valid  = b_valid_q;
        slv_resp_o.b.resp   = b_resp_q;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.r_valid  = r_valid_q;
        slv_resp_o.r.resp   = r_resp_q;
        slv_resp_o.r.data   = r_data_q;
    end

    always_comb begin
        reg_q_o = '0;
        for (int k = 0; k < NumRegs; k++) begin
            reg_q_o[k*AxiDataWidth +: AxiDataWidth] = regs_q[k];
        end
    end

    assign wr_pulse_o = wr_pulse_q;

    logic unused_prot;
    assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

`ifndef SYNTHESIS
    param_check: assert property (@(posedge clk_i)
        (AxiDataWidth == 32 || AxiDataWidth == 64) && NumRegs != 0);
    aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slv_req_i.aw_valid && !slv_resp_o.aw_ready) |=> $stable(slv_req_i.aw));
    w_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slv_req_i.w_valid && !slv_resp_o.w_ready) |=> $stable(slv_req_i.w));
    ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slv_req_i.ar_valid && !slv_resp_o.ar_ready) |=> $stable(slv_req_i.ar));
`endif

endmodule

// File: tb/tb_axi_lite_cfg_regs.sv
// Bench for axi_lite_cfg_regs: directed scenarios plus random traffic checked
// against a word-array model of the register file.

module tb_axi_lite_cfg_regs;
    import axi_lite_cfg_pkg::*;

    localparam int N = 4;
    localparam logic [N*32-1:0] RST_VAL = {32'hFFFF_FFFF, 32'h0000_1234, 32'h0000_0000, 32'h0000_00A5};
    localparam logic [N-1:0]    RO      = 4'b1000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    req_t            req;
    resp_t           resp;
    logic [N-1:0]    reg_load;
    logic [N*32-1:0] reg_d;
    logic [N*32-1:0] reg_q;
    logic [N-1:0]    wr_pulse;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl [N];

    always #5 clk = ~clk;

    axi_lite_cfg_regs #(
        .NumRegs   (N),
        .RegRstVal (RST_VAL),
        .ReadOnly  (RO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (req),
        .slv_resp_o (resp),
        .reg_load_i (reg_load),
        .reg_d_i    (reg_d),
        .reg_q_o    (reg_q),
        .wr_pulse_o (wr_pulse)
    );

    // ---------------- reference model ----------------
    task automatic mdl_reset();
        mdl[0] = 32'h0000_00A5;
        mdl[1] = 32'h0000_0000;
        mdl[2] = 32'h0000_1234;
        mdl[3] = 32'hFFFF_FFFF;
    endtask

    task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] exp_resp, output logic [3:0] exp_pulse);
        int k;
        k = int'(addr[3:2]);
        if (addr[31:4] != 0 || RO[k]) begin
            exp_resp  = 2'b10;
            exp_pulse = 4'b0000;
        end else begin
            exp_resp  = 2'b00;
            exp_pulse = 4'b0001 << k;
            for (int b = 0; b < 4; b++) if (strb[b]) mdl[k][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    function automatic logic [31:0] mdl_read_data(input logic [31:0] addr);
        return (addr[31:4] != 0) ? 32'h0 : mdl[int'(addr[3:2])];
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ({30'($urandom_range(0, 5)), 2'b00}) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(4, 31));
        return a;
    endfunction

    // ---------------- bus drivers (no checking) ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output bit rdy, output logic bv1, output logic [1:0] bresp,
                             output logic [3:0] p1, output logic bv2, output logic [3:0] p2);
        @(negedge clk);
        req.aw.addr = addr; req.aw.prot = '0;
        req.w.data = data;  req.w.strb = strb;
        req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            #1;
            if (resp.aw_ready && resp.w_ready) rdy = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        bv1 = resp.b_valid; bresp = resp.b.resp; p1 = wr_pulse;
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        @(negedge clk);
        bv2 = resp.b_valid; p2 = wr_pulse;
    endtask

    task automatic axi_read(input logic [31:0] addr, output bit rdy, output logic rv1,
                            output logic [31:0] rdata, output logic [1:0] rresp, output logic rv2);
        @(negedge clk);
        req.ar.addr = addr; req.ar.prot = '0;
        req.ar_valid = 1'b1; req.r_ready = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            #1;
            if (resp.ar_ready) rdy = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        rv1 = resp.r_valid; rdata = resp.r.data; rresp = resp.r.resp;
        req.ar_valid = 1'b0;
        @(negedge clk);
        rv2 = resp.r_valid;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req = '0; reg_load = '0; reg_d = '0;
        rst_n = 1'b0;
        mdl_reset();
        repeat (3) @(negedge clk);
        req.aw_valid = 1'b1; req.w_valid = 1'b1; req.r_ready = 1'b1; req.b_ready = 1'b1;
        #1;
        n_checks++; if (resp.b_valid !== 1'b0) begin n_errors++; $display("FAIL rst_b_valid: got %b expected 0", resp.b_valid); end
        n_checks++; if (resp.r_valid !== 1'b0) begin n_errors++; $display("FAIL rst_r_valid: got %b expected 0", resp.r_valid); end
        n_checks++; if ({resp.aw_ready, resp.w_ready, resp.ar_ready} !== 3'b000) begin n_errors++; $display("FAIL rst_readies: got %b expected 000", {resp.aw_ready, resp.w_ready, resp.ar_ready}); end
        n_checks++; if (wr_pulse !== 4'b0) begin n_errors++; $display("FAIL rst_wr_pulse: got %b expected 0000", wr_pulse); end
        n_checks++; if ({resp.b.resp, resp.r.resp, resp.r.data} !== 36'h0) begin n_errors++; $display("FAIL rst_payload: got %h expected 0", {resp.b.resp, resp.r.resp, resp.r.data}); end
        for (int k = 0; k < N; k++) begin
            n_checks++; if (reg_q[k*32 +: 32] !== mdl[k]) begin n_errors++; $display("FAIL rst_reg_q[%0d]: got %h expected %h", k, reg_q[k*32 +: 32], mdl[k]); end
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_all();
        bit rdy; logic rv1, rv2; logic [31:0] rd; logic [1:0] rr;
        for (int k = 0; k < N; k++) begin
            axi_read(32'(k * 4), rdy, rv1, rd, rr, rv2);
            n_checks++; if (!rdy) begin n_errors++; $display("FAIL rd_all_ready[%0d]: no ar_ready within bound", k); end
            n_checks++; if ({rv1, rv2} !== 2'b10) begin n_errors++; $display("FAIL rd_all_latency[%0d]: r_valid got %b expected 10", k, {rv1, rv2}); end
            n_checks++; if (rd !== mdl[k] || rr !== 2'b00) begin n_errors++; $display("FAIL rd_all_data[%0d]: got %h/%0d expected %h/0", k, rd, rr, mdl[k]); end
        end
    endtask

    task automatic test_strobe_write();
        bit rdy; logic bv1, bv2; logic [1:0] br, er; logic [3:0] p1, p2, ep;
        axi_write(32'h4, 32'hDEAD_BEEF, 4'b0101, rdy, bv1, br, p1, bv2, p2);
        mdl_write(32'h4, 32'hDEAD_BEEF, 4'b0101, er, ep);
        n_checks++; if (!rdy) begin n_errors++; $display("FAIL strb_ready: no aw/w ready within bound"); end
        n_checks++; if ({bv1, bv2} !== 2'b10 || br !== er) begin n_errors++; $display("FAIL strb_b: got valid %b resp %0d expected 10 resp %0d", {bv1, bv2}, br, er); end
        n_checks++; if (p1 !== 4'b0010 || p2 !== 4'b0000) begin n_errors++; $display("FAIL strb_pulse: got %b then %b expected 0010 then 0000", p1, p2); end
        n_checks++; if (reg_q[63:32] !== 32'h00AD_00EF) begin n_errors++; $display("FAIL strb_reg1: got %h expected 00ad00ef", reg_q[63:32]); end
    endtask

    task automatic test_errors();
        bit rdy; logic bv1, bv2, rv1, rv2; logic [1:0] br, er, rr; logic [3:0] p1, p2, ep; logic [31:0] rd;
        logic [31:0] addrs [3];
        logic [3:0]  strbs [3];
        addrs[0] = 32'h10; addrs[1] = 32'hC; addrs[2] = 32'h0;
        strbs[0] = 4'hF;   strbs[1] = 4'hF;  strbs[2] = 4'h0;
        for (int t = 0; t < 3; t++) begin
            logic [31:0] d;
            d = $urandom;
            axi_write(addrs[t], d, strbs[t], rdy, bv1, br, p1, bv2, p2);
            mdl_write(addrs[t], d, strbs[t], er, ep);
            n_checks++; if (!rdy || bv1 !== 1'b1 || br !== er) begin n_errors++; $display("FAIL err_wr_resp[%h]: got rdy %b valid %b resp %0d expected resp %0d", addrs[t], rdy, bv1, br, er); end
            n_checks++; if (p1 !== ep) begin n_errors++; $display("FAIL err_wr_pulse[%h]: got %b expected %b", addrs[t], p1, ep); end
            for (int k = 0; k < N; k++) begin
                n_checks++; if (reg_q[k*32 +: 32] !== mdl[k]) begin n_errors++; $display("FAIL err_reg_q[%0d]: got %h expected %h", k, reg_q[k*32 +: 32], mdl[k]); end
            end
        end
        axi_read(32'h10, rdy, rv1, rd, rr, rv2);
        n_checks++; if (!rdy || rv1 !== 1'b1 || rd !== 32'h0 || rr !== 2'b10) begin n_errors++; $display("FAIL err_rd_oor: got valid %b data %h resp %0d expected 1 0 2", rv1, rd, rr); end
        axi_read(32'hC, rdy, rv1, rd, rr, rv2);
        n_checks++; if (rd !== mdl[3] || rr !== 2'b00) begin n_errors++; $display("FAIL err_rd_ro: got %h/%0d expected %h/0", rd, rr, mdl[3]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2; logic [1:0] er1, er2; logic [3:0] ep1, ep2;
        d1 = $urandom; d2 = $urandom;
        @(negedge clk);
        req.aw.addr = 32'h0; req.w.data = d1; req.w.strb = 4'hF;
        req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b0;
        #1;
        n_checks++; if ({resp.aw_ready, resp.w_ready} !== 2'b11) begin n_errors++; $display("FAIL bp_first_accept: got %b expected 11", {resp.aw_ready, resp.w_ready}); end
        mdl_write(32'h0, d1, 4'hF, er1, ep1);
        @(negedge clk);
        req.aw.addr = 32'h4; req.w.data = d2;
        n_checks++; if (wr_pulse !== ep1) begin n_errors++; $display("FAIL bp_first_pulse: got %b expected %b", wr_pulse, ep1); end
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if ({resp.aw_ready, resp.w_ready} !== 2'b00) begin n_errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 00", i, {resp.aw_ready, resp.w_ready}); end
            n_checks++; if (resp.b_valid !== 1'b1 || resp.b.resp !== er1) begin n_errors++; $display("FAIL bp_stall_b[%0d]: got %b/%0d expected 1/%0d", i, resp.b_valid, resp.b.resp, er1); end
            @(negedge clk);
        end
        req.b_ready = 1'b1;
        #1;
        n_checks++; if ({resp.aw_ready, resp.w_ready} !== 2'b11) begin n_errors++; $display("FAIL bp_same_cycle_accept: got %b expected 11", {resp.aw_ready, resp.w_ready}); end
        mdl_write(32'h4, d2, 4'hF, er2, ep2);
        @(negedge clk);
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        n_checks++; if (resp.b_valid !== 1'b1 || resp.b.resp !== er2 || wr_pulse !== ep2) begin n_errors++; $display("FAIL bp_second_b: got %b/%0d pulse %b expected 1/%0d pulse %b", resp.b_valid, resp.b.resp, wr_pulse, er2, ep2); end
        for (int k = 0; k < N; k++) begin
            n_checks++; if (reg_q[k*32 +: 32] !== mdl[k]) begin n_errors++; $display("FAIL bp_reg_q[%0d]: got %h expected %h", k, reg_q[k*32 +: 32], mdl[k]); end
        end
        @(negedge clk);
        n_checks++; if (resp.b_valid !== 1'b0) begin n_errors++; $display("FAIL bp_b_drop: got %b expected 0", resp.b_valid); end
    endtask

    task automatic test_load_collision();
        logic [31:0] old; logic [1:0] er; logic [3:0] ep;
        old = mdl[2];
        @(negedge clk);
        reg_load[2] = 1'b1; reg_d[2*32 +: 32] = 32'h1111_1111;
        req.aw.addr = 32'h8; req.w.data = 32'h2222_2222; req.w.strb = 4'b0011;
        req.ar.addr = 32'h8;
        req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
        req.b_ready = 1'b1; req.r_ready = 1'b1;
        mdl[2] = 32'h1111_1111;
        mdl_write(32'h8, 32'h2222_2222, 4'b0011, er, ep);
        #1;
        n_checks++; if ({resp.aw_ready, resp.ar_ready} !== 2'b11) begin n_errors++; $display("FAIL col_accept: got %b expected 11", {resp.aw_ready, resp.ar_ready}); end
        @(negedge clk);
        reg_load = '0; req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
        n_checks++; if (reg_q[2*32 +: 32] !== 32'h1111_2222) begin n_errors++; $display("FAIL col_reg2: got %h expected 11112222", reg_q[2*32 +: 32]); end
        n_checks++; if (resp.r_valid !== 1'b1 || resp.r.data !== old || resp.r.resp !== 2'b00) begin n_errors++; $display("FAIL col_read_old: got %b %h/%0d expected 1 %h/0", resp.r_valid, resp.r.data, resp.r.resp, old); end
        n_checks++; if (resp.b_valid !== 1'b1 || resp.b.resp !== er || wr_pulse !== ep) begin n_errors++; $display("FAIL col_b: got %b/%0d pulse %b expected 1/%0d pulse %b", resp.b_valid, resp.b.resp, wr_pulse, er, ep); end
        @(negedge clk);
        n_checks++; if (wr_pulse !== 4'b0 || resp.r_valid !== 1'b0) begin n_errors++; $display("FAIL col_after: got pulse %b r_valid %b expected 0000 0", wr_pulse, resp.r_valid); end
    endtask

    task automatic test_random();
        bit rdy; logic bv1, bv2, rv1, rv2; logic [1:0] br, er, rr; logic [3:0] p1, p2, ep;
        logic [31:0] a, d, rd, ed; logic [3:0] s; int k;
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a = rand_addr(); d = $urandom; s = 4'($urandom_range(0, 15));
                    axi_write(a, d, s, rdy, bv1, br, p1, bv2, p2);
                    mdl_write(a, d, s, er, ep);
                    n_checks++; if (!rdy || {bv1, bv2} !== 2'b10 || br !== er) begin n_errors++; $display("FAIL rnd_wr_b[%h]: got rdy %b valid %b resp %0d expected resp %0d", a, rdy, {bv1, bv2}, br, er); end
                    n_checks++; if (p1 !== ep || p2 !== 4'b0) begin n_errors++; $display("FAIL rnd_wr_pulse[%h]: got %b then %b expected %b then 0000", a, p1, p2, ep); end
                end
                1: begin
                    a = rand_addr();
                    ed = mdl_read_data(a);
                    axi_read(a, rdy, rv1, rd, rr, rv2);
                    n_checks++; if (!rdy || {rv1, rv2} !== 2'b10 || rd !== ed || rr !== ((a[31:4] != 0) ? 2'b10 : 2'b00)) begin n_errors++; $display("FAIL rnd_rd[%h]: got valid %b data %h resp %0d expected data %h", a, {rv1, rv2}, rd, rr, ed); end
                end
                default: begin
                    k = $urandom_range(0, N - 1); d = $urandom;
                    @(negedge clk);
                    reg_load[k] = 1'b1; reg_d[k*32 +: 32] = d;
                    @(negedge clk);
                    reg_load = '0;
                    mdl[k] = d;
                end
            endcase
            for (int j = 0; j < N; j++) begin
                n_checks++; if (reg_q[j*32 +: 32] !== mdl[j]) begin n_errors++; $display("FAIL rnd_reg_q[%0d]: got %h expected %h", j, reg_q[j*32 +: 32], mdl[j]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit rdy; logic rv1, rv2; logic [31:0] rd; logic [1:0] rr;
        @(negedge clk);
        req.aw.addr = 32'h4; req.w.data = $urandom; req.w.strb = 4'hF;
        req.ar.addr = 32'h0;
        req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
        req.b_ready = 1'b0; req.r_ready = 1'b0;
        @(negedge clk);
        req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
        n_checks++; if ({resp.b_valid, resp.r_valid} !== 2'b11) begin n_errors++; $display("FAIL mid_pending: got %b expected 11", {resp.b_valid, resp.r_valid}); end
        #2;
        req.r_ready = 1'b1;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        n_checks++; if ({resp.b_valid, resp.r_valid} !== 2'b00) begin n_errors++; $display("FAIL mid_valid_drop: got %b expected 00", {resp.b_valid, resp.r_valid}); end
        n_checks++; if (resp.ar_ready !== 1'b0 || wr_pulse !== 4'b0) begin n_errors++; $display("FAIL mid_ready_pulse: got ar_ready %b pulse %b expected 0 0000", resp.ar_ready, wr_pulse); end
        for (int k = 0; k < N; k++) begin
            n_checks++; if (reg_q[k*32 +: 32] !== mdl[k]) begin n_errors++; $display("FAIL mid_reg_q[%0d]: got %h expected %h", k, reg_q[k*32 +: 32], mdl[k]); end
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        axi_read(32'h4, rdy, rv1, rd, rr, rv2);
        n_checks++; if (!rdy || rv1 !== 1'b1 || rd !== mdl[1] || rr !== 2'b00) begin n_errors++; $display("FAIL mid_readback: got valid %b data %h resp %0d expected 1 %h 0", rv1, rd, rr, mdl[1]); end
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_strobe_write();
        test_errors();
        test_back_to_back();
        test_load_collision();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/axi_lite_cfg_regs.md
Name: axi_lite_cfg_regs

Overview:
- AXI4-Lite register-file slave that terminates one master port of the AXI4-Lite crossbar; it is the downstream consumer of `mst_ports_req_o[j]` / `mst_ports_resp_i[j]`.
- Holds `NumRegs` word-wide configuration/status registers with per-register reset values and a per-register read-only mask.
- Hardware-side load inputs let status logic update registers.
- Responses are registered and carry full valid/ready back-pressure on B and R.

Parameters:
- NumRegs, 32'd4, number of AxiDataWidth-bit registers (≥1).
- AxiAddrWidth, 32'd32, AXI4-Lite address width.
- AxiDataWidth, 32'd32, data width; 32 or 64.
- RegRstVal, '0, packed NumRegs×AxiDataWidth reset value; register k is slice k.
- ReadOnly, '0, NumRegs-bit mask; bit k=1 makes register k read-only from AXI.
- req_t, logic, AXI4-Lite request struct.
- resp_t, logic, AXI4-Lite response struct.
- Dependent, do not override: RegIdxWidth = cf_math_pkg::idx_width(NumRegs).
- Dependent, do not override: WordOffset = $clog2(AxiDataWidth/8).

Ports:
- clk_i  input  1  clock, positive edge.
- rst_ni  input  1  asynchronous reset, active low.
- slv_req_i  input  req_t  AXI4-Lite request from crossbar master port.
- slv_resp_o  output  resp_t  AXI4-Lite response to crossbar.
- reg_load_i  input  NumRegs  per-register hardware load strobe.
- reg_d_i  input  NumRegs×AxiDataWidth  hardware load data.
- reg_q_o  output  NumRegs×AxiDataWidth  current register contents.
- wr_pulse_o  output  NumRegs  one-cycle pulse on a successful AXI write to register k.

Behaviour:
- Reset: registers take RegRstVal. b_valid, r_valid, aw_ready, w_ready, ar_ready and wr_pulse_o are all 0. b.resp, r.resp and r.data are 0.
- Clock and reset: one clock `clk_i`; reset `rst_ni` is asynchronous and active-low.
- Decode: idx = addr[WordOffset +: RegIdxWidth]. Bits below WordOffset are ignored. The access is out of range if idx ≥ NumRegs or any address bit above WordOffset+RegIdxWidth is set.
- Write accept: aw_ready and w_ready are asserted together, combinationally, when aw_valid && w_valid && (!b_valid_q || b_ready).
  - AW is never accepted without W, and W never without AW.
  - Accepting both in the same cycle as the B handshake is allowed (back-to-back writes, one per cycle).
- Write effect, on the accept edge:
  - In range and not ReadOnly: byte lanes with w.strb set are written; b.resp = OKAY; wr_pulse_o[idx] = 1 for exactly the following cycle.
  - Out of range: b.resp = SLVERR; no register changes.
  - ReadOnly: b.resp = SLVERR; no register changes.
  - strb = 0 on a valid register: OKAY, no change, wr_pulse_o still asserted.
- B channel: b_valid rises the cycle after accept (latency 1). It is held stable with resp stable until b_ready.
- Read accept: ar_ready = !r_valid_q || r_ready.
- Read response: on accept, r_valid is set the next cycle.
  - r.data = register value at the accept edge, before any same-edge write or load.
  - r.resp = OKAY in range; SLVERR with data 0 out of range.
  - ReadOnly registers read normally.
  - R is held stable until r_ready; one read per cycle sustained with r_ready high.
- AW/W and AR channels are independent. A read and a write to the same register in the same cycle returns the old value.
- Hardware load: reg_load_i[k] sets reg k = reg_d_i[k] at the next edge, for any k including ReadOnly registers.
  - If an AXI write to k is accepted in the same cycle, the AXI write wins on the strobed bytes; the load wins on unstrobed bytes.
- reg_q_o is driven directly from the registers: zero latency after the update edge.
- Reset mid-transaction: all pending B/R responses are dropped and all valid/ready go to 0 immediately (asynchronous).
- Assertions (translate_off): AxiDataWidth ∈ {32,64}; NumRegs ≥ 1; once asserted, aw/w/ar payload is stable while valid && !ready.

Test Plan:
- Reset then read all registers, RegRstVal={32'hA5,32'h0,32'h1234,32'hFFFF_FFFF} -> R data matches per index, resp OKAY, each r_valid 1 cycle after ar handshake.
- Write 32'hDEAD_BEEF strb 4'b0101 to reg1 (was 0) -> B OKAY after 1 cycle, wr_pulse_o=4'b0010 for one cycle, reg_q_o[1]=32'h00AD_00EF.
- Write to address 0x10 with NumRegs=4, and to reg3 with ReadOnly=4'b1000 -> both B SLVERR, no register change, wr_pulse_o stays 0; read of 0x10 -> SLVERR with data 0.
- b_ready held low 5 cycles with AW/W valid for a second write -> aw_ready/w_ready stay 0 and B stays stable; on b_ready=1 the second write is accepted in the same cycle.
- Same cycle: reg_load_i[2]=1 with reg_d_i[2]=32'h1111_1111, AXI write to reg2 with 32'h2222_2222 strb 4'b0011, AR to reg2 -> reg2=32'h1111_2222; R returns the old value.
- Assert rst_ni low while b_valid=1 and r_valid=1 -> both drop in the same cycle; registers return to RegRstVal.
